// File: rtl/stamp_counter_reg_master_if.sv
// Command, register-bus and response signals of the stamp counter register master.
// The master modport is the initiator's view; slave is the environment's view.
interface stamp_counter_reg_master_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned CNT_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_rd_wr_L;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wr_data;
    logic [CNT_WIDTH-1:0]  cmd_count;

    logic                  reg_req;
    logic                  reg_rd_wr_L;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wr_data;
    logic [DATA_WIDTH-1:0] reg_rd_data;
    logic                  reg_ack;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_timeout;
    logic                  rsp_last;

    logic                  busy;

    modport master (
        input  cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wr_data, cmd_count,
        output cmd_ready,
        output reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
        input  reg_rd_data, reg_ack,
        output rsp_valid, rsp_data, rsp_timeout, rsp_last,
        input  rsp_ready,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wr_data, cmd_count,
        input  cmd_ready,
        input  reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
        output reg_rd_data, reg_ack,
        input  rsp_valid, rsp_data, rsp_timeout, rsp_last,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/stamp_counter_reg_master.sv
// Register-bus initiator: turns single/burst commands into one req/ack transaction
// per word, with an ack timeout that substitutes 0xDEAD_BEEF for the lost beat.
module stamp_counter_reg_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned CNT_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                        clk,
    input logic                        reset,
    stamp_counter_reg_master_if.master bus
);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  beats_left;
    logic [WAIT_W-1:0]     wait_cnt;

    logic                  cmd_ready_q;
    logic                  busy_q;
    logic                  reg_req_q;
    logic                  reg_rd_wr_L_q;
    logic [ADDR_WIDTH-1:0] reg_addr_q;
    logic [DATA_WIDTH-1:0] reg_wr_data_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_timeout_q;
    logic                  rsp_last_q;

    // The ack seen in the first REQ cycle belongs to an earlier request edge.
    logic ack_ok_c;
    logic timed_out_c;
    assign ack_ok_c    = (wait_cnt != '0) && bus.reg_ack;
    assign timed_out_c = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            beats_left    <= '0;
            wait_cnt      <= '0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            reg_req_q     <= 1'b0;
            reg_rd_wr_L_q <= 1'b1;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_last_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        reg_addr_q    <= bus.cmd_addr;
                        reg_wr_data_q <= bus.cmd_wr_data;
                        reg_rd_wr_L_q <= bus.cmd_rd_wr_L;
                        beats_left    <= bus.cmd_count;
                        wait_cnt      <= '0;
                        reg_req_q     <= 1'b1;
                        cmd_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        state         <= REQ;
                    end
                end

                REQ: begin
                    if (ack_ok_c || timed_out_c) begin
                        // An ack arriving on the final wait cycle still wins.
                        rsp_data_q    <= ack_ok_c ? bus.reg_rd_data : TIMEOUT_DATA;
                        rsp_timeout_q <= !ack_ok_c;
                        rsp_last_q    <= (beats_left == '0);
                        rsp_valid_q   <= 1'b1;
                        reg_req_q     <= 1'b0;
                        state         <= RSP;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (beats_left == '0) begin
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            reg_addr_q <= reg_addr_q + ADDR_WIDTH'(1);
                            beats_left <= beats_left - CNT_WIDTH'(1);
                            wait_cnt   <= '0;
                            reg_req_q  <= 1'b1;
                            state      <= REQ;
                        end
                    end
                end

                default: begin
                    reg_req_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = busy_q;
    assign bus.reg_req     = reg_req_q;
    assign bus.reg_rd_wr_L = reg_rd_wr_L_q;
    assign bus.reg_addr    = reg_addr_q;
    assign bus.reg_wr_data = reg_wr_data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.rsp_last    = rsp_last_q;
endmodule

// File: tb/tb_stamp_counter_reg_master.sv
// Bench for stamp_counter_reg_master: behavioural register responder, transaction-level
// expectation queues built at command accept, and a per-cycle compare process.
module tb_stamp_counter_reg_master;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned CW = 4;
    localparam int unsigned TO = 255;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stamp_counter_reg_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    stamp_counter_reg_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] data;
        bit          tmo;
        bit          last;
    } rsp_t;

    typedef struct {
        logic [5:0]  addr;
        bit          rd;
        logic [31:0] wdata;
        int          len;
    } beat_t;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] rmem [64];
    logic [31:0] mmem [64];
    rsp_t        exp_rsp [$];
    beat_t       exp_beat [$];
    int          cfg_delay [16];
    bit          cfg_drop [16];
    bit          cfg_stale [16];
    bit          outstanding;
    int          beat_cnt;
    int          rdy_mode;
    bit          spurious_en;
    bit          late_ack;

    logic [5:0]  addr_log [$];
    int          len_log [$];
    rsp_t        rsp_log [$];

    logic [5:0]  t2_addr [4] = '{6'h3E, 6'h3F, 6'h00, 6'h01};
    bit          t2_last [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response and handshake checks; expectations for a command are built when it is accepted.
    logic [5:0] m_a;
    beat_t      m_b;
    rsp_t       m_r;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("cmd_ready", 32'(bus.cmd_ready), 32'(!outstanding));
                chk("busy", 32'(bus.busy), 32'(outstanding));
                if (bus.rsp_valid) begin
                    chk("req_low_in_rsp", 32'(bus.reg_req), 32'd0);
                    if (exp_rsp.size() == 0) begin
                        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                    end else begin
                        m_r = exp_rsp[0];
                        chk("rsp_data", bus.rsp_data, m_r.data);
                        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(m_r.tmo));
                        chk("rsp_last", 32'(bus.rsp_last), 32'(m_r.last));
                        if (bus.rsp_ready) begin
                            rsp_log.push_back(rsp_t'{bus.rsp_data, bus.rsp_timeout, bus.rsp_last});
                            void'(exp_rsp.pop_front());
                            if (m_r.last) outstanding = 1'b0;
                        end
                    end
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    for (int i = 0; i <= int'(bus.cmd_count); i++) begin
                        m_a = bus.cmd_addr + 6'(i);
                        m_b.addr  = m_a;
                        m_b.rd    = bus.cmd_rd_wr_L;
                        m_b.wdata = bus.cmd_wr_data;
                        m_b.len   = cfg_drop[i] ? int'(TO) + 1 : cfg_delay[i];
                        exp_beat.push_back(m_b);
                        if (cfg_drop[i]) begin
                            m_r.data = 32'hDEAD_BEEF;
                            m_r.tmo  = 1'b1;
                        end else begin
                            m_r.data = mmem[m_a];
                            m_r.tmo  = 1'b0;
                            if (!bus.cmd_rd_wr_L) mmem[m_a] = bus.cmd_wr_data;
                        end
                        m_r.last = (i == int'(bus.cmd_count));
                        exp_rsp.push_back(m_r);
                    end
                    beat_cnt    = 0;
                    outstanding = 1'b1;
                end
            end
        end
    end

    // Register responder: acks a configurable number of cycles after req rises, returns the old value.
    int    r_age;
    bit    r_prev;
    int    r_b;
    beat_t r_cur;
    initial begin
        r_age = 0;
        r_prev = 1'b0;
        r_b = 0;
        bus.reg_ack = 1'b0;
        bus.reg_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.reg_ack = 1'b0;
            bus.reg_rd_data = $urandom;
            if (reset) begin
                r_age  = 0;
                r_prev = 1'b0;
            end else if (bus.reg_req) begin
                if (!r_prev) begin
                    r_age = 1;
                    r_b = (beat_cnt < 16) ? beat_cnt : 15;
                    beat_cnt++;
                    addr_log.push_back(bus.reg_addr);
                    if (exp_beat.size() == 0) begin
                        chk("unexpected_req", 32'(bus.reg_req), 32'd0);
                    end else begin
                        r_cur = exp_beat.pop_front();
                        chk("reg_addr", 32'(bus.reg_addr), 32'(r_cur.addr));
                        chk("reg_rd_wr_L", 32'(bus.reg_rd_wr_L), 32'(r_cur.rd));
                        if (!r_cur.rd) chk("reg_wr_data", bus.reg_wr_data, r_cur.wdata);
                    end
                end else begin
                    r_age++;
                end
                if (r_age == 1 && cfg_stale[r_b]) begin
                    bus.reg_ack = 1'b1;
                end else if (!cfg_drop[r_b] && r_age == cfg_delay[r_b]) begin
                    bus.reg_ack = 1'b1;
                    bus.reg_rd_data = rmem[bus.reg_addr];
                    if (!bus.reg_rd_wr_L) rmem[bus.reg_addr] = bus.reg_wr_data;
                end
                r_prev = 1'b1;
            end else begin
                if (r_prev) begin
                    len_log.push_back(r_age);
                    chk("req_len", 32'(r_age), 32'(r_cur.len));
                end else if (late_ack || (spurious_en && $urandom_range(0, 7) == 0)) begin
                    bus.reg_ack = 1'b1;
                    late_ack = 1'b0;
                end
                r_prev = 1'b0;
            end
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic set_cfg_default();
        for (int i = 0; i < 16; i++) begin
            cfg_delay[i] = 2;
            cfg_drop[i]  = 1'b0;
            cfg_stale[i] = 1'b0;
        end
    endtask

    task automatic clear_logs();
        addr_log.delete();
        len_log.delete();
        rsp_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        exp_rsp.delete();
        exp_beat.delete();
        outstanding = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic issue_cmd(input bit rd, input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] count);
        int k;
        @(posedge clk);
        #1;
        bus.cmd_valid   = 1'b1;
        bus.cmd_rd_wr_L = rd;
        bus.cmd_addr    = addr;
        bus.cmd_wr_data = data;
        bus.cmd_count   = count;
        @(negedge clk);
        k = 0;
        while (!bus.cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.cmd_ready) chk("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_addr    = 6'($urandom);
        bus.cmd_wr_data = $urandom;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 6000 && outstanding; k++) @(negedge clk);
        if (outstanding) begin
            chk("cmd_complete", 32'(outstanding), 32'd0);
            do_reset();
        end
    endtask

    logic [3:0] rnd_cnt;
    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_rd_wr_L = 1'b1;
        bus.cmd_addr = '0;
        bus.cmd_wr_data = '0;
        bus.cmd_count = '0;
        rdy_mode = 0;
        spurious_en = 1'b0;
        late_ack = 1'b0;
        outstanding = 1'b0;
        beat_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            rmem[i] = $urandom;
            mmem[i] = rmem[i];
        end
        set_cfg_default();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_reg_req", 32'(bus.reg_req), 32'd0);
        chk("rst_reg_rd_wr_L", 32'(bus.reg_rd_wr_L), 32'd1);
        chk("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        chk("rst_reg_wr_data", bus.reg_wr_data, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        chk("rst_rsp_last", 32'(bus.rsp_last), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // Single read latency with an immediate responder
        rmem[5] = 32'h1234_5678;
        mmem[5] = 32'h1234_5678;
        clear_logs();
        issue_cmd(1'b1, 6'h05, 32'h0, 4'd0);
        @(negedge clk);
        chk("t1_req_c0", 32'(bus.reg_req), 32'd1);
        chk("t1_valid_c0", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_req_c1", 32'(bus.reg_req), 32'd1);
        chk("t1_valid_c1", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_req_c2", 32'(bus.reg_req), 32'd0);
        chk("t1_valid_c2", 32'(bus.rsp_valid), 32'd1);
        chk("t1_data", bus.rsp_data, 32'h1234_5678);
        chk("t1_last", 32'(bus.rsp_last), 32'd1);
        chk("t1_timeout", 32'(bus.rsp_timeout), 32'd0);
        wait_done();
        chk("t1_len_count", 32'(len_log.size()), 32'd1);
        if (len_log.size() == 1) chk("t1_req_len", 32'(len_log[0]), 32'd2);

        // Burst write across the address wrap, then read back one word
        clear_logs();
        issue_cmd(1'b0, 6'h3E, 32'hA5A5_A5A5, 4'd3);
        wait_done();
        chk("t2_beats", 32'(addr_log.size()), 32'd4);
        chk("t2_rsps", 32'(rsp_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) chk("t2_addr_seq", 32'(addr_log[i]), 32'(t2_addr[i]));
            if (i < rsp_log.size()) chk("t2_last_seq", 32'(rsp_log[i].last), 32'(t2_last[i]));
        end
        clear_logs();
        issue_cmd(1'b1, 6'h3F, 32'h0, 4'd0);
        wait_done();
        if (rsp_log.size() == 1) chk("t2_readback", rsp_log[0].data, 32'hA5A5_A5A5);

        // Middle beat of a 3-beat read never acked
        rdy_mode = 1;
        cfg_drop[1] = 1'b1;
        clear_logs();
        issue_cmd(1'b1, 6'h10, 32'h0, 4'd2);
        wait_done();
        set_cfg_default();
        chk("t3_rsps", 32'(rsp_log.size()), 32'd3);
        chk("t3_lens", 32'(len_log.size()), 32'd3);
        if (rsp_log.size() == 3) begin
            chk("t3_b1_tmo", 32'(rsp_log[0].tmo), 32'd0);
            chk("t3_b2_data", rsp_log[1].data, 32'hDEAD_BEEF);
            chk("t3_b2_tmo", 32'(rsp_log[1].tmo), 32'd1);
            chk("t3_b3_tmo", 32'(rsp_log[2].tmo), 32'd0);
        end
        if (len_log.size() == 3) chk("t3_b2_len", 32'(len_log[1]), 32'd256);

        // Response backpressure
        rdy_mode = 2;
        rmem[6'h20] = 32'h0BAD_F00D;
        mmem[6'h20] = 32'h0BAD_F00D;
        issue_cmd(1'b1, 6'h20, 32'h0, 4'd0);
        for (int k = 0; k < 20 && !bus.rsp_valid; k++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk("t4_valid_hold", 32'(bus.rsp_valid), 32'd1);
            chk("t4_data_hold", bus.rsp_data, 32'h0BAD_F00D);
            chk("t4_req_low", 32'(bus.reg_req), 32'd0);
            chk("t4_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
            @(negedge clk);
        end
        rdy_mode = 0;
        wait_done();

        // Spurious ack while idle, then stale ack in the first request cycle
        late_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_idle_valid", 32'(bus.rsp_valid), 32'd0);
            chk("t5_idle_req", 32'(bus.reg_req), 32'd0);
        end
        rmem[7] = 32'hCAFE_F00D;
        mmem[7] = 32'hCAFE_F00D;
        cfg_stale[0] = 1'b1;
        clear_logs();
        issue_cmd(1'b1, 6'h07, 32'h0, 4'd0);
        wait_done();
        set_cfg_default();
        if (rsp_log.size() == 1) chk("t5_data", rsp_log[0].data, 32'hCAFE_F00D);
        if (len_log.size() == 1) chk("t5_req_len", 32'(len_log[0]), 32'd2);

        // Reset while waiting for an ack, followed by a late ack
        cfg_drop[0] = 1'b1;
        issue_cmd(1'b1, 6'h03, 32'h0, 4'd0);
        repeat (5) @(negedge clk);
        chk("t6_req_before", 32'(bus.reg_req), 32'd1);
        do_reset();
        set_cfg_default();
        @(negedge clk);
        chk("t6_req", 32'(bus.reg_req), 32'd0);
        chk("t6_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        late_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_late_valid", 32'(bus.rsp_valid), 32'd0);
            chk("t6_late_req", 32'(bus.reg_req), 32'd0);
        end

        // Randomized commands against the model
        rdy_mode = 1;
        spurious_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 16; i++) begin
                cfg_delay[i] = $urandom_range(2, 5);
                cfg_stale[i] = ($urandom_range(0, 4) == 0);
                cfg_drop[i]  = ($urandom_range(0, 39) == 0);
            end
            rnd_cnt = (n % 15 == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            issue_cmd(1'($urandom_range(0, 1)), 6'($urandom), $urandom, rnd_cnt);
            wait_done();
        end
        spurious_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
